// File: rtl/cmd_tx.sv
// Response framer: SYNC, HDR, SIZE, optional payload and optional CRC-8 onto the FT245 Tx stream.
// Optional feature: define CMD_TX_CRC_EN to append CRC-8 (poly 0x07) over HDR, SIZE and payload.
module cmd_tx #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rsp_valid,
    output logic       o_rsp_ready,
    input  logic       i_rsp_wr,
    input  logic [7:0] i_rsp_size,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_st_data,
    output logic       o_st_valid,
    input  logic       i_st_ready,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_HDR,
        S_SIZE,
`ifdef CMD_TX_CRC_EN
        S_CRC,
`endif
        S_DATA
    } state_t;

`ifdef CMD_TX_CRC_EN
    localparam state_t END_STATE = S_CRC;
`else
    localparam state_t END_STATE = S_IDLE;
`endif

    state_t     r_state;
    state_t     w_state_next;
    logic       r_wr;
    logic [7:0] r_size;
    logic [7:0] r_cnt;
    logic [7:0] r_st_data;
    logic       r_st_valid;
    logic       r_data_done;
    logic       w_st_xfer;
    logic       w_tx_ready;
    logic       w_tx_xfer;
    logic       w_rsp_ready;

`ifdef CMD_TX_CRC_EN
    logic [7:0] r_crc;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    // Ready outputs are held low while reset is asserted, not only after the reset edge.
    assign w_rsp_ready = (r_state == S_IDLE) && i_rst_n;
    assign w_st_xfer   = r_st_valid && i_st_ready;
    assign w_tx_ready  = (r_state == S_DATA) && !r_data_done && (!r_st_valid || i_st_ready);
    assign w_tx_xfer   = w_tx_ready && i_tx_valid;

    assign o_rsp_ready = w_rsp_ready;
    assign o_tx_ready  = w_tx_ready;
    assign o_st_data   = r_st_data;
    assign o_st_valid  = r_st_valid;
    assign o_busy      = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (i_rsp_valid && w_rsp_ready) w_state_next = S_SYNC;
            S_SYNC: if (w_st_xfer) w_state_next = S_HDR;
            S_HDR:  if (w_st_xfer) w_state_next = S_SIZE;
            S_SIZE: if (w_st_xfer) w_state_next = r_wr ? END_STATE : S_DATA;
            S_DATA: if (r_data_done && w_st_xfer) w_state_next = END_STATE;
`ifdef CMD_TX_CRC_EN
            S_CRC:  if (w_st_xfer) w_state_next = S_IDLE;
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // The output register is refilled in the same cycle it drains, so DATA runs at 1 byte/cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr        <= 1'b0;
            r_size      <= 8'h00;
            r_cnt       <= 8'h00;
            r_st_data   <= 8'h00;
            r_st_valid  <= 1'b0;
            r_data_done <= 1'b0;
`ifdef CMD_TX_CRC_EN
            r_crc       <= 8'h00;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (i_rsp_valid) begin
                    r_wr        <= i_rsp_wr;
                    r_size      <= i_rsp_size;
                    r_st_data   <= SYNC_BYTE;
                    r_st_valid  <= 1'b1;
                    r_data_done <= 1'b0;
`ifdef CMD_TX_CRC_EN
                    r_crc       <= 8'h00;
`endif
                end
                S_SYNC: if (w_st_xfer) begin
                    r_st_data <= {7'b0, r_wr};
`ifdef CMD_TX_CRC_EN
                    r_crc     <= crc8_byte(r_crc, {7'b0, r_wr});
`endif
                end
                S_HDR: if (w_st_xfer) begin
                    r_st_data <= r_size;
                    r_cnt     <= r_size;
`ifdef CMD_TX_CRC_EN
                    r_crc     <= crc8_byte(r_crc, r_size);
`endif
                end
                S_SIZE: if (w_st_xfer) begin
`ifdef CMD_TX_CRC_EN
                    if (r_wr) r_st_data  <= r_crc;
                    else      r_st_valid <= 1'b0;
`else
                    r_st_valid <= 1'b0;
`endif
                end
                S_DATA: begin
                    if (w_tx_xfer) begin
                        r_st_data  <= i_tx_data;
                        r_st_valid <= 1'b1;
`ifdef CMD_TX_CRC_EN
                        r_crc      <= crc8_byte(r_crc, i_tx_data);
`endif
                        if (r_cnt == 8'h00) r_data_done <= 1'b1;
                        else                r_cnt       <= r_cnt - 8'h01;
                    end else if (w_st_xfer) begin
`ifdef CMD_TX_CRC_EN
                        if (r_data_done) r_st_data  <= r_crc;
                        else             r_st_valid <= 1'b0;
`else
                        r_st_valid <= 1'b0;
`endif
                    end
                end
`ifdef CMD_TX_CRC_EN
                S_CRC: if (w_st_xfer) r_st_valid <= 1'b0;
`endif
                default: r_st_valid <= 1'b0;
            endcase
        end
    end

endmodule
